// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: operation encodings, FSM states and default sizes shared by tinyalu_param
package tinyalu_pkg;
  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    sub_op = 3'b101,
    rst_op = 3'b111
  } operation_t;
  typedef enum logic {IDLE, EXEC} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_MUL_LAT = 3;
  function automatic logic is_illegal(logic [2:0] op);
    return op[2] & op[1];
  endfunction
endpackage

// File: rtl/tinyalu_param_if.sv
// tinyalu_param_if: command/result bundle between the tester and the ALU
interface tinyalu_param_if #(parameter int WIDTH = tinyalu_pkg::DEF_WIDTH);
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2:0]         op;
  logic               start;
  logic               busy;
  logic               done;
  logic               err;
  logic [2*WIDTH-1:0] result;
  modport master (output A, B, op, start, input busy, done, err, result);
  modport slave (input A, B, op, start, output busy, done, err, result);
endinterface

// File: rtl/tinyalu_mul_pipe.sv
// tinyalu_mul_pipe: MUL_LAT-stage unsigned multiplier with a travelling valid bit
module tinyalu_mul_pipe #(
  parameter int WIDTH = 8,
  parameter int MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] product
);
  logic [MUL_LAT-1:0]   r_v;
  logic [2*WIDTH-1:0]   r_p [MUL_LAT];
  // Stage 0 forms the product; later stages only delay it alongside its valid bit
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_v <= '0;
      for (int i = 0; i < MUL_LAT; i++) r_p[i] <= '0;
    end else begin
      r_v[0] <= in_valid;
      r_p[0] <= {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      for (int i = 1; i < MUL_LAT; i++) begin
        r_v[i] <= r_v[i-1];
        r_p[i] <= r_p[i-1];
      end
    end
  assign out_valid = r_v[MUL_LAT-1];
  assign product = r_p[MUL_LAT-1];
endmodule

// File: rtl/tinyalu_param.sv
// tinyalu_param: one-command-at-a-time ALU with pipelined multiply, busy and illegal-op error
module tinyalu_param import tinyalu_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic          clk,
  input  logic          reset_n,
  tinyalu_param_if.slave bus
);
  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [2:0]         r_op;
  logic [2*WIDTH-1:0] r_result, w_res, w_a, w_b, w_prod;
  logic               r_done, r_err, w_accept, w_fin, w_mul_valid;
  assign w_a = {{WIDTH{1'b0}}, r_a};
  assign w_b = {{WIDTH{1'b0}}, r_b};
  tinyalu_mul_pipe #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) u_mul (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (w_accept && bus.op == mul_op),
    .a         (bus.A),
    .b         (bus.B),
    .out_valid (w_mul_valid),
    .product   (w_prod)
  );
  // Acceptance, completion and next state; non-mul ops finish on their first EXEC edge
  always_comb begin
    w_accept = bus.start && r_state == IDLE && bus.op != no_op;
    w_fin = r_state == EXEC && (r_op != mul_op || w_mul_valid);
    w_next = w_accept ? EXEC : w_fin ? IDLE : r_state;
    w_res = r_op == add_op ? w_a + w_b
          : r_op == and_op ? w_a & w_b
          : r_op == xor_op ? w_a ^ w_b
          : r_op == sub_op ? w_a - w_b
          : r_op == mul_op ? w_prod : '0;
  end
  // State register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  // Command capture and the result/done/err registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_a <= '0;
      r_b <= '0;
      r_op <= '0;
      r_result <= '0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a <= bus.A;
        r_b <= bus.B;
        r_op <= bus.op;
      end
      r_done <= w_fin;
      r_err <= w_fin && is_illegal(r_op);
      if (w_fin) r_result <= w_res;
    end
  assign bus.busy = r_state == EXEC;
  assign bus.done = r_done;
  assign bus.err = r_err;
  assign bus.result = r_result;
endmodule

// File: tb/tb_tinyalu_param.sv
// tb_tinyalu_param: scoreboard bench for tinyalu_param at 8/3, 16/5 and 4/1
module tb_tinyalu_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [64:0] exp_q[$];
  logic [64:0] e;

  always #5 clk = ~clk;

  tinyalu_param_if #(.WIDTH(8))  b8();
  tinyalu_param_if #(.WIDTH(16)) b16();
  tinyalu_param_if #(.WIDTH(4))  b4();

  tinyalu_param #(.WIDTH(8),  .MUL_LAT(3)) dut8  (.clk(clk), .reset_n(rst_n), .bus(b8));
  tinyalu_param #(.WIDTH(16), .MUL_LAT(5)) dut16 (.clk(clk), .reset_n(rst_n), .bus(b16));
  tinyalu_param #(.WIDTH(4),  .MUL_LAT(1)) dut4  (.clk(clk), .reset_n(rst_n), .bus(b4));

  function automatic logic [64:0] model(int w, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] x, y, m, r;
    x = {32'd0, a};
    y = {32'd0, b};
    m = (64'd1 << (2 * w)) - 64'd1;
    case (op)
      3'b001: r = x + y;
      3'b010: r = x & y;
      3'b011: r = x ^ y;
      3'b100: r = x * y;
      3'b101: r = x - y;
      default: r = 64'd0;
    endcase
    return {op >= 3'd6, r & m};
  endfunction

  task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    b8.A = a; b8.B = b; b8.op = op; b8.start = 1'b1;
    if (op != 3'b000) exp_q.push_back(model(8, op, {24'd0, a}, {24'd0, b}));
    @(posedge clk); #1;
    b8.start = 1'b0;
  endtask

  task automatic wait8(input int max, output int cyc);
    cyc = 0;
    while (b8.done !== 1'b1 && cyc < max) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (b8.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", b8.busy); end
    checks++; if (b8.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", b8.done); end
    checks++; if (b8.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", b8.err); end
    checks++; if (b8.result !== 16'h0) begin failures++; $display("FAIL reset_result got=%h exp=0000", b8.result); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_add;
    int cyc;
    issue8(3'b001, 8'hFF, 8'h01);
    checks++; if (b8.busy !== 1'b1) begin failures++; $display("FAIL add_busy got=%b exp=1", b8.busy); end
    wait8(5, cyc);
    e = exp_q.pop_front();
    checks++; if (cyc != 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", cyc); end
    checks++; if (b8.result !== e[15:0]) begin failures++; $display("FAIL add_result got=%h exp=%h", b8.result, e[15:0]); end
    checks++; if (b8.err !== 1'b0) begin failures++; $display("FAIL add_err got=%b exp=0", b8.err); end
    checks++; if (b8.busy !== 1'b0) begin failures++; $display("FAIL add_busy_at_done got=%b exp=0", b8.busy); end
    @(posedge clk); #1;
    checks++; if (b8.done !== 1'b0) begin failures++; $display("FAIL add_done_pulse got=%b exp=0", b8.done); end
    checks++; if (b8.result !== 16'h0100) begin failures++; $display("FAIL add_result_hold got=%h exp=0100", b8.result); end
  endtask

  task automatic test_mul;
    int cyc;
    issue8(3'b100, 8'hFF, 8'hFF);
    @(posedge clk); #1;
    checks++; if (b8.busy !== 1'b1 || b8.done !== 1'b0) begin failures++; $display("FAIL mul_midflight got=busy%b/done%b exp=busy1/done0", b8.busy, b8.done); end
    wait8(6, cyc);
    e = exp_q.pop_front();
    checks++; if (cyc + 1 != 3) begin failures++; $display("FAIL mul_latency got=%0d exp=3", cyc + 1); end
    checks++; if (b8.result !== e[15:0]) begin failures++; $display("FAIL mul_result got=%h exp=%h", b8.result, e[15:0]); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops [3];
    logic [7:0] as [3];
    logic [7:0] bs [3];
    int cyc;
    ops = '{3'b101, 3'b010, 3'b011};
    as = '{8'h03, 8'hF0, 8'hF0};
    bs = '{8'h05, 8'h3C, 8'h3C};
    for (int i = 0; i < 3; i++) begin
      issue8(ops[i], as[i], bs[i]);
      checks++; if (b8.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept%0d got=%b exp=1", i, b8.busy); end
      wait8(5, cyc);
      e = exp_q.pop_front();
      checks++; if (cyc != 1) begin failures++; $display("FAIL b2b_latency%0d got=%0d exp=1", i, cyc); end
      checks++; if (b8.result !== e[15:0]) begin failures++; $display("FAIL b2b_result%0d got=%h exp=%h", i, b8.result, e[15:0]); end
    end
  endtask

  task automatic test_start_held;
    int cyc, n_done;
    @(negedge clk);
    b8.A = 8'h03; b8.B = 8'h05; b8.op = 3'b100; b8.start = 1'b1;
    exp_q.push_back(model(8, 3'b100, 32'd3, 32'd5));
    @(posedge clk); #1;
    cyc = 0; n_done = 0;
    while (cyc < 8 && n_done == 0) begin
      @(negedge clk);
      b8.A = 8'($urandom); b8.B = 8'($urandom); b8.op = 3'($urandom_range(1, 7));
      @(posedge clk); #1;
      cyc++;
      if (b8.done === 1'b1) begin
        n_done++;
        e = exp_q.pop_front();
        checks++; if (b8.result !== e[15:0]) begin failures++; $display("FAIL held_result got=%h exp=%h", b8.result, e[15:0]); end
      end
    end
    checks++; if (cyc != 3) begin failures++; $display("FAIL held_latency got=%0d exp=3", cyc); end
    @(negedge clk) b8.start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (b8.done === 1'b1) n_done++;
    end
    checks++; if (n_done != 1) begin failures++; $display("FAIL held_done_count got=%0d exp=1", n_done); end
  endtask

  task automatic test_illegal;
    int cyc, n_done;
    for (int i = 6; i < 8; i++) begin
      issue8(3'(i), 8'h5A, 8'hA5);
      wait8(5, cyc);
      e = exp_q.pop_front();
      checks++; if (cyc != 1) begin failures++; $display("FAIL illegal%0d_latency got=%0d exp=1", i, cyc); end
      checks++; if (b8.err !== e[64]) begin failures++; $display("FAIL illegal%0d_err got=%b exp=%b", i, b8.err, e[64]); end
      checks++; if (b8.result !== e[15:0]) begin failures++; $display("FAIL illegal%0d_result got=%h exp=%h", i, b8.result, e[15:0]); end
    end
    issue8(3'b000, 8'h11, 8'h22);
    checks++; if (b8.busy !== 1'b0) begin failures++; $display("FAIL noop_busy got=%b exp=0", b8.busy); end
    n_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (b8.done === 1'b1) n_done++;
    end
    checks++; if (n_done != 0) begin failures++; $display("FAIL noop_done_count got=%0d exp=0", n_done); end
  endtask

  task automatic test_reset_mid;
    int cyc, n_done;
    issue8(3'b001, 8'h10, 8'h20);
    wait8(5, cyc);
    e = exp_q.pop_front();
    checks++; if (b8.result !== e[15:0]) begin failures++; $display("FAIL pre_reset_result got=%h exp=%h", b8.result, e[15:0]); end
    issue8(3'b100, 8'h0C, 8'h0B);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++; if (b8.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", b8.busy); end
    checks++; if (b8.done !== 1'b0 || b8.err !== 1'b0) begin failures++; $display("FAIL midreset_done_err got=%b%b exp=00", b8.done, b8.err); end
    checks++; if (b8.result !== 16'h0) begin failures++; $display("FAIL midreset_result got=%h exp=0000", b8.result); end
    @(negedge clk) rst_n = 1'b1;
    n_done = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (b8.done === 1'b1) n_done++;
    end
    checks++; if (n_done != 0) begin failures++; $display("FAIL midreset_stray_done got=%0d exp=0", n_done); end
    issue8(3'b001, 8'h12, 8'h34);
    wait8(5, cyc);
    e = exp_q.pop_front();
    checks++; if (cyc != 1) begin failures++; $display("FAIL post_reset_latency got=%0d exp=1", cyc); end
    checks++; if (b8.result !== e[15:0]) begin failures++; $display("FAIL post_reset_result got=%h exp=%h", b8.result, e[15:0]); end
  endtask

  task automatic test_random_w16;
    logic [2:0] op;
    logic [15:0] a, b;
    int cyc, lat;
    for (int n = 0; n < 30; n++) begin
      op = 3'($urandom_range(1, 7)); a = 16'($urandom); b = 16'($urandom);
      lat = op == 3'b100 ? 5 : 1;
      @(negedge clk);
      b16.A = a; b16.B = b; b16.op = op; b16.start = 1'b1;
      exp_q.push_back(model(16, op, {16'd0, a}, {16'd0, b}));
      @(posedge clk); #1;
      b16.start = 1'b0;
      cyc = 0;
      while (b16.done !== 1'b1 && cyc < 10) begin
        @(posedge clk); #1;
        cyc++;
      end
      e = exp_q.pop_front();
      checks++; if (cyc != lat) begin failures++; $display("FAIL w16_latency op=%0d got=%0d exp=%0d", op, cyc, lat); end
      checks++; if (b16.result !== e[31:0] || b16.err !== e[64]) begin failures++; $display("FAIL w16_result op=%0d a=%h b=%h got=%b/%h exp=%b/%h", op, a, b, b16.err, b16.result, e[64], e[31:0]); end
      repeat ($urandom_range(0, 1)) @(posedge clk);
    end
  endtask

  task automatic test_random_w4;
    logic [2:0] op;
    logic [3:0] a, b;
    int cyc;
    for (int n = 0; n < 30; n++) begin
      op = 3'($urandom_range(1, 7)); a = 4'($urandom); b = 4'($urandom);
      @(negedge clk);
      b4.A = a; b4.B = b; b4.op = op; b4.start = 1'b1;
      exp_q.push_back(model(4, op, {28'd0, a}, {28'd0, b}));
      @(posedge clk); #1;
      b4.start = 1'b0;
      cyc = 0;
      while (b4.done !== 1'b1 && cyc < 6) begin
        @(posedge clk); #1;
        cyc++;
      end
      e = exp_q.pop_front();
      checks++; if (cyc != 1) begin failures++; $display("FAIL w4_latency op=%0d got=%0d exp=1", op, cyc); end
      checks++; if (b4.result !== e[7:0] || b4.err !== e[64]) begin failures++; $display("FAIL w4_result op=%0d a=%h b=%h got=%b/%h exp=%b/%h", op, a, b, b4.err, b4.result, e[64], e[7:0]); end
      repeat ($urandom_range(0, 1)) @(posedge clk);
    end
  endtask

  initial begin
    b8.A = '0;  b8.B = '0;  b8.op = '0;  b8.start = 1'b0;
    b16.A = '0; b16.B = '0; b16.op = '0; b16.start = 1'b0;
    b4.A = '0;  b4.B = '0;  b4.op = '0;  b4.start = 1'b0;
    test_reset;
    test_add;
    test_mul;
    test_back_to_back;
    test_start_held;
    test_illegal;
    test_reset_mid;
    test_random_w16;
    test_random_w4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
